// File: rtl/ram32_byte_host.sv
// rtl/ram32_byte_host.sv - byte-stream command front end for a 32x32 byte-writable RAM macro
module ram32_byte_host (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_byte,
  input  logic        rsp_ready,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [4:0]  ram_a,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_MASK, S_DATA, S_WR, S_ACK, S_RD, S_CAP, S_RSP
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [31:0] shift;
  logic [1:0]  cnt;
  logic        ready_en;
  logic        cmd_acc;
  logic        rsp_acc;

  // ready_en holds cmd_ready low during reset and until the first edge after release
  assign cmd_ready = ready_en && (state == S_IDLE || state == S_MASK || state == S_DATA);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign rsp_acc   = rsp_valid && rsp_ready;

  // RAM and status outputs are decoded from registers only; reset clears any pulse at once
  always_comb begin
    ram_en    = (state == S_WR) || (state == S_RD);
    ram_we    = (state == S_WR) ? mask : 4'h0;
    ram_a     = addr;
    ram_di    = wdata;
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_ACK) || (state == S_RSP);
    rsp_byte  = 8'h00;
    if (state == S_ACK) begin
      rsp_byte = {3'b101, addr};
    end else if (state == S_RSP) begin
      rsp_byte = shift[7:0];
    end
  end

  // next-state decode for frame parsing, RAM access and response streaming
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (cmd_acc) state_nx = cmd_byte[7] ? (cmd_byte[6] ? S_MASK : S_DATA) : S_RD;
      S_MASK: if (cmd_acc) state_nx = S_DATA;
      S_DATA: if (cmd_acc && cnt == 2'd3) state_nx = S_WR;
      S_WR:   state_nx = S_ACK;
      S_ACK:  if (rsp_ready) state_nx = S_IDLE;
      S_RD:   state_nx = S_CAP;
      S_CAP:  state_nx = S_RSP;
      S_RSP:  if (rsp_ready && cnt == 2'd3) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
    end
  end

  // frame datapath: address/mask capture, LSB-first word assembly, read shift-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= 5'd0;
      mask  <= 4'h0;
      wdata <= 32'd0;
      shift <= 32'd0;
      cnt   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: if (cmd_acc) begin
          addr <= cmd_byte[4:0];
          mask <= 4'hF;
          cnt  <= 2'd0;
        end
        S_MASK: if (cmd_acc) mask <= cmd_byte[3:0];
        S_DATA: if (cmd_acc) begin
          wdata <= {cmd_byte, wdata[31:8]};
          cnt   <= cnt + 2'd1;
        end
        S_CAP: begin
          shift <= ram_do;
          cnt   <= 2'd0;
        end
        S_RSP: if (rsp_acc) begin
          shift <= {8'h00, shift[31:8]};
          cnt   <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
